// File: rtl/shift_alu_seq_pkg.sv
// Shared constants for the sequential shift-then-ALU datapath: operation codes,
// FSM state encodings and flag bit positions.
package shift_alu_seq_pkg;

  // Shift modes applied to operand A, one bit per cycle
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // ALU operations; codes 101..111 all pass the shifted A through
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_EXEC  = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/shift_alu_seq_if.sv
// Request/response bundle for shift_alu_seq. master = requester/consumer side,
// slave = the datapath.
interface shift_alu_seq_if #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
);
  import shift_alu_seq_pkg::*;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // The request side holds in_valid and its payload until accepted; the datapath
  // holds out_valid, result and alu_flags stable until out_ready is seen.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic [1:0]       shmode;
  logic [2:0]       alu_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  flags_t           alu_flags;

  modport master (
    output in_valid, a, b, shamt, shmode, alu_ctrl, out_ready,
    input  in_ready, out_valid, result, alu_flags
  );

  modport slave (
    input  in_valid, a, b, shamt, shmode, alu_ctrl, out_ready,
    output in_ready, out_valid, result, alu_flags
  );

endinterface

// File: rtl/shift_alu_seq_alu_core.sv
// Combinational ALU: adds, subtracts, bitwise ops or passes A, and derives NZCV.
// Subtraction reuses the adder as a + ~b + 1 so C means "no borrow".
module alu_core
  import shift_alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);

  logic             is_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic             ovf;

  assign is_sub = (alu_ctrl == ALU_SUB);
  assign b_op   = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (alu_ctrl)
      ALU_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      default: result = a;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/shift_alu_seq.sv
// Sequential shift-then-ALU unit: accepts one request, shifts A one bit per cycle,
// runs the ALU once, and holds the registered result until the consumer takes it.
module shift_alu_seq
  import shift_alu_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_alu_seq_if.slave bus,
  output logic [1:0]     state_dbg
);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       mode_q;
  logic [2:0]       ctrl_q;
  logic [SHW-1:0]   count;
  logic [WIDTH-1:0] result_q;
  flags_t           flags_q;

  logic [SHW-1:0]   shamt_mod;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] alu_result;
  flags_t           alu_flag;

  // Only matters for non-power-of-two widths; folds to a plain wire otherwise
  assign shamt_mod = SHW'({{(32-SHW){1'b0}}, bus.shamt} % 32'(WIDTH));

  always_comb begin
    shift_nxt = a_q;
    case (mode_q)
      SH_LSL:  shift_nxt = {a_q[WIDTH-2:0], 1'b0};
      SH_LSR:  shift_nxt = {1'b0, a_q[WIDTH-1:1]};
      SH_ASR:  shift_nxt = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
      SH_ROR:  shift_nxt = {a_q[0], a_q[WIDTH-1:1]};
      default: shift_nxt = a_q;
    endcase
  end

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a        (a_q),
    .b        (b_q),
    .alu_ctrl (ctrl_q),
    .result   (alu_result),
    .flags    (alu_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= '0;
      ctrl_q   <= '0;
      count    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            mode_q <= bus.shmode;
            ctrl_q <= bus.alu_ctrl;
            count  <= shamt_mod;
            state  <= (shamt_mod != '0) ? ST_SHIFT : ST_EXEC;
          end
        end
        ST_SHIFT: begin
          a_q   <= shift_nxt;
          count <= count - SHW'(1);
          if (count == SHW'(1)) state <= ST_EXEC;
        end
        ST_EXEC: begin
          result_q <= alu_result;
          flags_q  <= alu_flag;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.result    = result_q;
  assign bus.alu_flags = flags_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_shift_alu_seq.sv
// Bench for shift_alu_seq (WIDTH=8): directed and random requests, a reference
// model on plain integers, and a monitor that drains an expected-result queue.
module tb_shift_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] state_dbg;

  shift_alu_seq_if #(.WIDTH(8)) bus();

  shift_alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference: {result[7:0], N, Z, C, V} computed from the arithmetic definition
  function automatic logic [11:0] model(input int a, input int b, input int sh,
                                        input int mode, input int ctrl);
    int s, r, t;
    logic n, z, c, v;
    case (mode)
      0:       s = (a << sh) & 255;
      1:       s = a >> sh;
      2:       s = (sx(a) >>> sh) & 255;
      default: s = ((a >> sh) | (a << (8 - sh))) & 255;
    endcase
    c = 1'b0;
    v = 1'b0;
    case (ctrl)
      0: begin
        r = s + b;
        c = (r > 255);
        t = sx(s) + sx(b);
        v = (t > 127) || (t < -128);
      end
      1: begin
        r = s - b;
        c = (s >= b);
        t = sx(s) - sx(b);
        v = (t > 127) || (t < -128);
      end
      2:       r = s & b;
      3:       r = s | b;
      4:       r = s ^ b;
      default: r = s;
    endcase
    r = r & 255;
    n = (r >= 128);
    z = (r == 0);
    return {r[7:0], n, z, c, v};
  endfunction

  // Monitor: every accepted output must match the oldest outstanding expectation
  always @(negedge clk) begin
    logic [11:0] e;
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got result %0h with no request outstanding", bus.result);
      end else begin
        e = exp_q.pop_front();
        check("result", 32'(bus.result), 32'(e[11:4]));
        check("flags", 32'(bus.alu_flags), 32'(e[3:0]));
      end
    end
  end

  // Issues one request, checks latency, optionally stalls the consumer for 'hold' cycles
  task automatic do_op(input int a, input int b, input int sh, input int mode,
                       input int ctrl, input int hold, input bit junk);
    logic [11:0] e;
    int          edges;
    bit          seen;
    e = model(a, b, sh, mode, ctrl);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.out_ready = (hold == 0);
    bus.a         = a[7:0];
    bus.b         = b[7:0];
    bus.shamt     = sh[2:0];
    bus.shmode    = mode[1:0];
    bus.alu_ctrl  = ctrl[2:0];
    bus.in_valid  = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #2 bus.in_valid = 1'b0;
    edges = 1;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #2 edges++;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL latency_timeout: out_valid never rose, expected after %0d edges", sh + 2);
      exp_q.delete();
      bus.out_ready = 1'b1;
      return;
    end
    check("latency", edges, sh + 2);
    for (int k = 0; k < hold; k++) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_result", 32'(bus.result), 32'(e[11:4]));
      check("hold_flags", 32'(bus.alu_flags), 32'(e[3:0]));
      @(posedge clk);
      #2;
      if (junk) begin
        bus.in_valid = 1'b1;
        bus.a        = 8'($urandom_range(0, 255));
        bus.shamt    = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
    end
    if (hold > 0) begin
      @(posedge clk);
      #2 bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.shamt     = '0;
    bus.shmode    = '0;
    bus.alu_ctrl  = '0;
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", 32'(bus.alu_flags), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #2;

    do_op(8'h03, 8'h01, 2, 0, 0, 0, 1'b0);
    do_op(8'h80, 8'hFF, 3, 2, 2, 0, 1'b0);
    do_op(8'h80, 8'h00, 3, 1, 4, 0, 1'b0);
    do_op(8'h05, 8'h05, 0, 0, 1, 0, 1'b0);
    do_op(8'h7F, 8'h01, 0, 0, 0, 0, 1'b0);
    do_op(8'hFF, 8'h01, 0, 0, 0, 0, 1'b0);
    do_op(8'h01, 8'h5A, 1, 3, 5, 5, 1'b1);
    @(negedge clk);
    check("idle_after_hold", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #2;

    // Abort a long shift with reset; the aborted request must never appear
    bus.a        = 8'h81;
    bus.b        = 8'h11;
    bus.shamt    = 3'd7;
    bus.shmode   = 2'b00;
    bus.alu_ctrl = 3'b000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #2 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 check("mid_shift_state", 32'(state_dbg), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_flags", 32'(bus.alu_flags), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2;
    do_op(8'h40, 8'h22, 2, 1, 1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_op($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7),
            $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 2),
            1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
